special_result_generator: RTL

//  Encoder counterpart of the divider's special-case detection: consumes per-operand special-case codes
//  and rebuilds the packed HUB result word for X/Y when the quotient is fixed by the special case.

---
 rtl/special_result_generator.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/special_result_generator.sv
// rtl/special_result_generator.sv - divider special-case result encoder with valid/ready skid stage
//
// Purpose: rebuilds the packed HUB quotient word when the X/Y special-case codes
// fix the result, and registers it behind a valid/ready handshake with a
// one-entry skid buffer, which sustains full throughput without a combinational
// path from out_ready to in_ready.
//
// Optional feature macro: SPECIAL_FLAGS_EN (adds out_invalid / out_div_zero).
//
// Ports:
//   clk, rst_l                  clock, asynchronous active-low reset
//   in_valid / in_ready         upstream handshake
//   X, Y_sign                   packed dividend, divisor sign bit
//   X_special_case              0 none, 1 +inf, 2 -inf, 3 +0, 4 -0 (others none)
//   Y_special_case              0 none, 1 +inf, 2 -inf, 3 +0, 4 -0, 5 +1, 6 -1 (7 none)
//   X_one                       forwarded unchanged to out_x_one
//   out_valid / out_ready       downstream handshake
//   out_result, out_special     special quotient word and its select flag
//   out_x_one                   registered X_one
//   out_invalid, out_div_zero   exception flags (SPECIAL_FLAGS_EN only)

`timescale 1ns/1ps

module special_result_generator #(
    parameter int M            = 23,
    parameter int E            = 8,
    parameter int special_case = 7,
    localparam int CW          = $clog2(special_case),
    localparam int W           = E + M + 1
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  X,
    input  logic          Y_sign,
    input  logic [CW-1:0] X_special_case,
    input  logic [CW-1:0] Y_special_case,
    input  logic          X_one,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_result,
    output logic          out_special,
`ifdef SPECIAL_FLAGS_EN
    output logic          out_invalid,
    output logic          out_div_zero,
`endif
    output logic          out_x_one
);

    localparam logic [E+M-1:0] MAG_ONES  = {(E+M){1'b1}};
    localparam logic [E+M-1:0] MAG_ZEROS = {(E+M){1'b0}};

    // Special-case classification of the incoming beat
    logic x_inf, x_zero, y_inf, y_zero, y_pone, y_mone, q_sign;

    assign x_inf  = (X_special_case == CW'(1)) || (X_special_case == CW'(2));
    assign x_zero = (X_special_case == CW'(3)) || (X_special_case == CW'(4));
    assign y_inf  = (Y_special_case == CW'(1)) || (Y_special_case == CW'(2));
    assign y_zero = (Y_special_case == CW'(3)) || (Y_special_case == CW'(4));
    assign y_pone = (Y_special_case == CW'(5));
    assign y_mone = (Y_special_case == CW'(6));
    assign q_sign = X[W-1] ^ Y_sign;

    logic [W-1:0] d_result;
    logic         d_special;

    // First match wins; indeterminate forms return positive infinity.
    always_comb begin
        d_result  = '0;
        d_special = 1'b1;
        if ((x_inf && y_inf) || (x_zero && y_zero)) begin
            d_result = {1'b0, MAG_ONES};
        end else if (x_inf) begin
            d_result = {q_sign, MAG_ONES};
        end else if (x_zero) begin
            d_result = {q_sign, MAG_ZEROS};
        end else if (y_inf) begin
            d_result = {q_sign, MAG_ZEROS};
        end else if (y_zero) begin
            d_result = {q_sign, MAG_ONES};
        end else if (y_pone) begin
            d_result = X;
        end else if (y_mone) begin
            d_result = {~X[W-1], X[W-2:0]};
        end else begin
            d_special = 1'b0;
        end
    end

    // Handshake control
    logic accept, out_free, skid_full;
    logic load_from_in, load_from_skid, load_skid;

    assign in_ready       = ~skid_full;
    assign accept         = in_valid & in_ready;
    assign out_free       = ~out_valid | out_ready;
    // With the skid full, in_ready is low, so accept and skid drain never collide.
    assign load_from_skid = out_free & skid_full;
    assign load_from_in   = out_free & ~skid_full & accept;
    assign load_skid      = ~out_free & accept;

    logic [W-1:0] skid_result;
    logic         skid_special, skid_x_one;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_special  <= 1'b0;
            out_x_one    <= 1'b0;
            skid_full    <= 1'b0;
            skid_result  <= '0;
            skid_special <= 1'b0;
            skid_x_one   <= 1'b0;
        end else begin
            if (load_from_skid) begin
                out_valid   <= 1'b1;
                out_result  <= skid_result;
                out_special <= skid_special;
                out_x_one   <= skid_x_one;
                skid_full   <= 1'b0;
            end else if (load_from_in) begin
                out_valid   <= 1'b1;
                out_result  <= d_result;
                out_special <= d_special;
                out_x_one   <= X_one;
            end else if (out_free) begin
                out_valid   <= 1'b0;
            end
            if (load_skid) begin
                skid_full    <= 1'b1;
                skid_result  <= d_result;
                skid_special <= d_special;
                skid_x_one   <= X_one;
            end
        end
    end

`ifdef SPECIAL_FLAGS_EN
    logic d_invalid, d_div_zero;
    logic skid_invalid, skid_div_zero;

    assign d_invalid  = (x_inf & y_inf) | (x_zero & y_zero);
    // Division by zero only when nothing earlier in the priority chain matched.
    assign d_div_zero = y_zero & ~x_inf & ~x_zero & ~y_inf;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            out_invalid   <= 1'b0;
            out_div_zero  <= 1'b0;
            skid_invalid  <= 1'b0;
            skid_div_zero <= 1'b0;
        end else begin
            if (load_from_skid) begin
                out_invalid  <= skid_invalid;
                out_div_zero <= skid_div_zero;
            end else if (load_from_in) begin
                out_invalid  <= d_invalid;
                out_div_zero <= d_div_zero;
            end
            if (load_skid) begin
                skid_invalid  <= d_invalid;
                skid_div_zero <= d_div_zero;
            end
        end
    end
`endif

endmodule
